// File: rtl/uart_frame_scheduler_if.sv
// Handshake bundle between the frame scheduler, its word requesters and the UART TX byte engine.
interface uart_frame_scheduler_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]      req_valid;
    logic [32*NREQ-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 tx_valid;
    logic [7:0]           tx_byte;
    logic                 tx_ready;

    modport master (
        input  req_valid, req_data, tx_ready,
        output req_ready, tx_valid, tx_byte
    );

    modport slave (
        output req_valid, req_data, tx_ready,
        input  req_ready, tx_valid, tx_byte
    );
endinterface

// File: rtl/uart_frame_scheduler.sv
// Round-robin arbiter that grants one requester's 32-bit word and ships it to a byte UART
// as a 6-byte frame: {HDR_TAG, grant_id}, data MSB first, XOR checksum.
module uart_frame_scheduler #(
    parameter int unsigned NREQ    = 4,
    parameter logic [4:0]  HDR_TAG = 5'b10100
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    uart_frame_scheduler_if.master bus,
    output logic                   busy,
    output logic [2:0]             grant_id,
    output logic                   frame_done
);

    localparam int unsigned GW = 3;
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CSUM
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       word_q, word_d;
    logic [GW-1:0]     last_q, last_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   req_ready_q, req_ready_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [GW-1:0]     win_c;
    logic [31:0]       win_word_c;
    logic [7:0]        csum_c;
    logic              accept_c;

    // First valid requester found scanning upward from last+1, wrapping modulo NREQ.
    function automatic logic [GW-1:0] rr_pick(input logic [NREQ-1:0] v, input logic [GW-1:0] last);
        logic [GW-1:0] pick;
        logic          found;
        int unsigned   idx;
        pick  = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = (32'(last) + i) % NREQ;
            if (!found && v[IW'(idx)]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
        return pick;
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [CW-1:0] n);
        logic [7:0] b;
        case (n)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    assign win_c    = rr_pick(bus.req_valid, last_q);
    assign accept_c = tx_valid_q && bus.tx_ready;
    assign csum_c   = {HDR_TAG, grant_q} ^ word_q[31:24] ^ word_q[23:16] ^ word_q[15:8] ^ word_q[7:0];

    always_comb begin
        win_word_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_c == GW'(i)) win_word_c = bus.req_data[32*i +: 32];
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        last_d      = last_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        req_ready_d = '0;
        tx_valid_d  = tx_valid_q;
        tx_byte_d   = tx_byte_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable && (|bus.req_valid)) begin
                    state_d     = S_HDR;
                    word_d      = win_word_c;
                    last_d      = win_c;
                    grant_d     = win_c;
                    req_ready_d = NREQ'(1) << win_c;
                    tx_valid_d  = 1'b1;
                    tx_byte_d   = {HDR_TAG, win_c};
                    busy_d      = 1'b1;
                end
            end
            S_HDR: begin
                if (accept_c) begin
                    state_d   = S_DATA;
                    cnt_d     = '0;
                    tx_byte_d = word_q[31:24];
                end
            end
            S_DATA: begin
                if (accept_c) begin
                    if (cnt_q == CW'(3)) begin
                        state_d   = S_CSUM;
                        tx_byte_d = csum_c;
                    end else begin
                        cnt_d     = cnt_q + CW'(1);
                        tx_byte_d = byte_sel(word_q, cnt_q + CW'(1));
                    end
                end
            end
            S_CSUM: begin
                if (accept_c) begin
                    state_d    = S_IDLE;
                    tx_valid_d = 1'b0;
                    tx_byte_d  = 8'h00;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            last_q      <= GW'(NREQ - 1);
            grant_q     <= '0;
            cnt_q       <= '0;
            req_ready_q <= '0;
            tx_valid_q  <= 1'b0;
            tx_byte_q   <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            tx_valid_q  <= tx_valid_d;
            tx_byte_q   <= tx_byte_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_byte   = tx_byte_q;
    assign busy          = busy_q;
    assign grant_id      = grant_q;
    assign frame_done    = done_q;

endmodule
